// File: rtl/seq_rec_trig.sv
// Pattern-match trigger for the sequence recorder: watches a masked compare on the
// sampled stream and emits a one-cycle start pulse after a match count and delay.
module seq_rec_trig #(
    parameter int IN_BITS  = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                SEQ_CLK,
    input  logic                RST_N,
    input  logic [IN_BITS-1:0]  SEQ_IN,
    input  logic                ARM,
    input  logic                ABORT,
    input  logic [IN_BITS-1:0]  TRIG_MASK,
    input  logic [IN_BITS-1:0]  TRIG_VALUE,
    input  logic                TRIG_EDGE,
    input  logic                TRIG_CONT,
    input  logic [CNT_BITS-1:0] TRIG_COUNT,
    input  logic [CNT_BITS-1:0] TRIG_DELAY,
    output logic [IN_BITS-1:0]  SEQ_OUT,
    output logic                SEQ_EXT_START,
    output logic                ARMED,
    output logic [CNT_BITS-1:0] FIRE_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ALL  = {CNT_BITS{1'b1}};

    state_t              state_r;
    logic [IN_BITS-1:0]  in_q_r;
    logic [IN_BITS-1:0]  mid_r;
    logic [IN_BITS-1:0]  out_r;
    logic                prev_hit_r;
    logic [CNT_BITS-1:0] mcnt_r;
    logic [CNT_BITS-1:0] dcnt_r;
    logic [CNT_BITS-1:0] fire_cnt_r;
    logic                start_r;
    logic                armed_r;

    logic                hit_s;
    logic                qual_s;
    logic [CNT_BITS:0]   need_s;
    logic [CNT_BITS:0]   mnext_s;
    logic                count_done_s;
    logic                delay_zero_s;
    logic                delay_done_s;

    // Match decode on the first pipeline stage; a zero count behaves as one.
    always_comb begin
        hit_s        = (((in_q_r ^ TRIG_VALUE) & TRIG_MASK) == {IN_BITS{1'b0}});
        qual_s       = hit_s & (~TRIG_EDGE | ~prev_hit_r);
        need_s       = (TRIG_COUNT == CNT_ZERO) ? {1'b0, CNT_ONE} : {1'b0, TRIG_COUNT};
        mnext_s      = {1'b0, mcnt_r} + {1'b0, CNT_ONE};
        count_done_s = (mnext_s >= need_s);
        delay_zero_s = (TRIG_DELAY == CNT_ZERO);
        delay_done_s = (dcnt_r == (TRIG_DELAY - CNT_ONE));
    end

    // Three-stage data pipeline; prev_hit resets high so no edge is seen straight out of reset.
    always_ff @(posedge SEQ_CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_q_r     <= {IN_BITS{1'b0}};
            mid_r      <= {IN_BITS{1'b0}};
            out_r      <= {IN_BITS{1'b0}};
            prev_hit_r <= 1'b1;
        end else begin
            in_q_r     <= SEQ_IN;
            mid_r      <= in_q_r;
            out_r      <= mid_r;
            prev_hit_r <= hit_s;
        end
    end

    // Trigger FSM with registered pulse, armed flag and fire counter.
    always_ff @(posedge SEQ_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            mcnt_r     <= CNT_ZERO;
            dcnt_r     <= CNT_ZERO;
            fire_cnt_r <= CNT_ZERO;
            start_r    <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            start_r <= 1'b0;
            if (ABORT) begin
                state_r <= ST_IDLE;
                armed_r <= 1'b0;
            end else if (ARM) begin
                state_r <= ST_ARMED;
                mcnt_r  <= CNT_ZERO;
                armed_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        armed_r <= 1'b0;
                    end
                    ST_ARMED: begin
                        // A match coinciding with the previous pulse is not counted.
                        if (qual_s && !start_r) begin
                            if (count_done_s && !delay_zero_s) begin
                                state_r <= ST_DELAY;
                                dcnt_r  <= CNT_ZERO;
                            end else if (count_done_s) begin
                                start_r    <= 1'b1;
                                fire_cnt_r <= fire_cnt_r + CNT_ONE;
                                mcnt_r     <= CNT_ZERO;
                                state_r    <= TRIG_CONT ? ST_ARMED : ST_IDLE;
                                armed_r    <= TRIG_CONT;
                            end else begin
                                mcnt_r <= (mcnt_r == CNT_ALL) ? mcnt_r : mcnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_DELAY: begin
                        dcnt_r <= dcnt_r + CNT_ONE;
                        if (delay_done_s) begin
                            start_r    <= 1'b1;
                            fire_cnt_r <= fire_cnt_r + CNT_ONE;
                            mcnt_r     <= CNT_ZERO;
                            state_r    <= TRIG_CONT ? ST_ARMED : ST_IDLE;
                            armed_r    <= TRIG_CONT;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        armed_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SEQ_OUT       = out_r;
    assign SEQ_EXT_START = start_r;
    assign ARMED         = armed_r;
    assign FIRE_CNT      = fire_cnt_r;

endmodule

// File: tb/tb_seq_rec_trig.sv
// Directed bench for seq_rec_trig: level, edge/count, delay, abort/restart,
// async reset, continuous mode and a 32-bit masked compare.
module tb_seq_rec_trig;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seq_in;
    logic        arm;
    logic        abort;
    logic [7:0]  mask;
    logic [7:0]  value;
    logic        edge_mode;
    logic        cont;
    logic [15:0] count;
    logic [15:0] delay;
    logic [7:0]  seq_out;
    logic        start;
    logic        armed;
    logic [15:0] fire_cnt;

    logic [31:0] seq_in32;
    logic        arm32;
    logic        abort32;
    logic [31:0] mask32;
    logic [31:0] value32;
    logic        edge32;
    logic        cont32;
    logic [15:0] count32;
    logic [15:0] delay32;
    logic [31:0] seq_out32;
    logic        start32;
    logic        armed32;
    logic [15:0] fire_cnt32;

    int checks;
    int failures;
    logic [7:0] edge_vec [9];

    seq_rec_trig #(.IN_BITS(8), .CNT_BITS(16)) dut (
        .SEQ_CLK(clk), .RST_N(rst_n), .SEQ_IN(seq_in), .ARM(arm), .ABORT(abort),
        .TRIG_MASK(mask), .TRIG_VALUE(value), .TRIG_EDGE(edge_mode), .TRIG_CONT(cont),
        .TRIG_COUNT(count), .TRIG_DELAY(delay), .SEQ_OUT(seq_out),
        .SEQ_EXT_START(start), .ARMED(armed), .FIRE_CNT(fire_cnt)
    );

    seq_rec_trig #(.IN_BITS(32), .CNT_BITS(16)) dut32 (
        .SEQ_CLK(clk), .RST_N(rst_n), .SEQ_IN(seq_in32), .ARM(arm32), .ABORT(abort32),
        .TRIG_MASK(mask32), .TRIG_VALUE(value32), .TRIG_EDGE(edge32), .TRIG_CONT(cont32),
        .TRIG_COUNT(count32), .TRIG_DELAY(delay32), .SEQ_OUT(seq_out32),
        .SEQ_EXT_START(start32), .ARMED(armed32), .FIRE_CNT(fire_cnt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; seq_in = 8'h00; arm = 1'b0; abort = 1'b0;
        mask = 8'hFF; value = 8'hA5; edge_mode = 1'b0; cont = 1'b0;
        count = 16'd1; delay = 16'd0;
        seq_in32 = 32'h0; arm32 = 1'b0; abort32 = 1'b0;
        mask32 = 32'hFFFF_0000; value32 = 32'h1234_0000; edge32 = 1'b0; cont32 = 1'b0;
        count32 = 16'd1; delay32 = 16'd0;
        step(); step();
        chk("rst_seq_out", 32'(seq_out), 32'h0);
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_armed", 32'(armed), 32'h0);
        chk("rst_fire_cnt", 32'(fire_cnt), 32'h0);
        rst_n = 1'b1;
        step(); step();

        // Level trigger, count 1, delay 0
        pulse_arm();
        chk("lvl_armed", 32'(armed), 32'h1);
        seq_in = 8'h00; step();
        seq_in = 8'h00; step();
        seq_in = 8'hA5; step();
        seq_in = 8'h00;
        chk("lvl_no_early", 32'(start), 32'h0);
        step();
        chk("lvl_pulse", 32'(start), 32'h1);
        chk("lvl_fire_cnt", 32'(fire_cnt), 32'h1);
        chk("lvl_disarm", 32'(armed), 32'h0);
        step();
        chk("lvl_pulse_end", 32'(start), 32'h0);
        chk("lvl_seq_out", 32'(seq_out), 32'hA5);

        // Edge mode, count 3: held run counts once
        edge_mode = 1'b1; count = 16'd3;
        step();
        pulse_arm();
        edge_vec = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00};
        for (int i = 0; i < 9; i++) begin
            seq_in = edge_vec[i];
            step();
            chk($sformatf("edge_start_%0d", i), 32'(start), 32'(i == 8));
        end
        step();
        chk("edge_fire_cnt", 32'(fire_cnt), 32'h2);
        chk("edge_disarm", 32'(armed), 32'h0);

        // Delay of 5: pulse 7 cycles after the match word
        edge_mode = 1'b0; count = 16'd1; delay = 16'd5;
        step();
        pulse_arm();
        seq_in = 8'hA5;
        for (int k = 1; k <= 7; k++) begin
            step();
            seq_in = 8'h00;
            chk($sformatf("dly_start_%0d", k), 32'(start), 32'(k == 7));
            chk($sformatf("dly_armed_%0d", k), 32'(armed), 32'(k != 7));
        end
        chk("dly_fire_cnt", 32'(fire_cnt), 32'h3);

        // Abort during delay cancels the pulse
        pulse_arm();
        seq_in = 8'hA5;
        step(); seq_in = 8'h00;
        step(); step(); step();
        abort = 1'b1;
        chk("abort_armed_before", 32'(armed), 32'h1);
        step();
        abort = 1'b0;
        chk("abort_armed_after", 32'(armed), 32'h0);
        for (int k = 6; k <= 9; k++) begin
            step();
            chk($sformatf("abort_nopulse_%0d", k), 32'(start), 32'h0);
        end
        chk("abort_fire_cnt", 32'(fire_cnt), 32'h3);

        // ARM and ABORT together: ABORT wins
        pulse_arm();
        chk("both_pre_armed", 32'(armed), 32'h1);
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        chk("both_idle", 32'(armed), 32'h0);

        // ARM during delay restarts and discards the pending pulse
        pulse_arm();
        seq_in = 8'hA5;
        step(); seq_in = 8'h00;
        step(); step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("restart_armed", 32'(armed), 32'h1);
        for (int k = 5; k <= 8; k++) begin
            step();
            chk($sformatf("restart_nopulse_%0d", k), 32'(start), 32'h0);
        end
        abort = 1'b1; step(); abort = 1'b0;

        // Zero mask: edge mode never fires, level mode fires on first armed cycle
        mask = 8'h00; edge_mode = 1'b1; delay = 16'd0;
        step(); step();
        pulse_arm();
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("zm_edge_nopulse_%0d", k), 32'(start), 32'h0);
        end
        abort = 1'b1; step(); abort = 1'b0;
        edge_mode = 1'b0;
        step();
        pulse_arm();
        chk("zm_lvl_first", 32'(start), 32'h0);
        step();
        chk("zm_lvl_pulse", 32'(start), 32'h1);
        chk("zm_lvl_fire_cnt", 32'(fire_cnt), 32'h4);

        // Async reset in the middle of a delay
        mask = 8'hFF; value = 8'hA5; delay = 16'd5;
        step(); step();
        pulse_arm();
        seq_in = 8'hA5;
        step(); step();
        chk("ar_armed_delay", 32'(armed), 32'h1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_seq_out", 32'(seq_out), 32'h0);
        chk("ar_start", 32'(start), 32'h0);
        chk("ar_armed", 32'(armed), 32'h0);
        chk("ar_fire_cnt", 32'(fire_cnt), 32'h0);
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("ar_nopulse_%0d", k), 32'(start | armed), 32'h0);
        end

        // Continuous mode on a counting stream
        seq_in = 8'h00; mask = 8'h0F; value = 8'h03; cont = 1'b1; delay = 16'd0;
        step(); step();
        pulse_arm();
        for (int i = 0; i < 256; i++) begin
            seq_in = 8'(i);
            step();
            chk($sformatf("cont_start_%0d", i), 32'(start), 32'((i & 15) == 4));
            if (i >= 2) begin
                chk($sformatf("cont_seq_out_%0d", i), 32'(seq_out), 32'((i - 2) & 255));
            end
        end
        seq_in = 8'h00;
        step(); step();
        chk("cont_fire_cnt", 32'(fire_cnt), 32'd16);
        chk("cont_armed", 32'(armed), 32'h1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("cont_abort", 32'(armed), 32'h0);

        // 32-bit masked compare on the upper half
        arm32 = 1'b1; step(); arm32 = 1'b0;
        seq_in32 = 32'h1235_BEEF;
        step(); seq_in32 = 32'h0;
        step();
        chk("w32_no_fire", 32'(start32), 32'h0);
        chk("w32_still_armed", 32'(armed32), 32'h1);
        seq_in32 = 32'h1234_BEEF;
        step(); seq_in32 = 32'h0;
        step();
        chk("w32_fire", 32'(start32), 32'h1);
        chk("w32_fire_cnt", 32'(fire_cnt32), 32'h1);
        step();
        chk("w32_seq_out", seq_out32, 32'h1234_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_rec_trig.md
Name: seq_rec_trig

Overview:
- Pattern-match trigger generator in the SEQ_CLK domain, directly upstream of the sequence recorder.
- Watches SEQ_IN for a masked pattern and emits a one-cycle SEQ_EXT_START pulse after a programmable match count and delay.
- Forwards the input stream (SEQ_OUT), delayed so the recorder's first stored word is the triggering word when TRIG_DELAY=0.
- Configuration inputs are quasi-static; the bus-side register block synchronises them.

Parameters:
IN_BITS, 8, width of sampled sequence word (4, 8, 16, 32)
CNT_BITS, 16, width of delay, match-count and fire counters

Ports:
SEQ_CLK  input  1  sequence clock; all logic on rising edge
RST_N  input  1  asynchronous active-low reset
SEQ_IN  input  IN_BITS  sampled sequence word
ARM  input  1  one-cycle pulse: arm trigger
ABORT  input  1  one-cycle pulse: return to IDLE
TRIG_MASK  input  IN_BITS  1 = bit participates in compare
TRIG_VALUE  input  IN_BITS  compare value
TRIG_EDGE  input  1  1 = match only on non-match→match transition
TRIG_CONT  input  1  1 = re-arm automatically after fire
TRIG_COUNT  input  CNT_BITS  fire on Nth qualifying match (0 treated as 1)
TRIG_DELAY  input  CNT_BITS  cycles between qualifying match and pulse
SEQ_OUT  output  IN_BITS  SEQ_IN delayed 3 cycles
SEQ_EXT_START  output  1  one-cycle trigger pulse to recorder
ARMED  output  1  high in ARMED or DELAY
FIRE_CNT  output  CNT_BITS  number of pulses since reset, wraps

Behaviour:
- Async reset (RST_N=0):
  - State IDLE.
  - SEQ_OUT=0, SEQ_EXT_START=0, ARMED=0, FIRE_CNT=0.
  - Pipeline registers and counters = 0; previous-match flag = 1, which blocks a spurious first edge.
- Pipeline:
  - in_q <= SEQ_IN every cycle.
  - hit = ((in_q ^ TRIG_VALUE) & TRIG_MASK) == 0, combinational on in_q.
  - prev_hit <= hit every cycle, in every state.
  - qual = hit & (~TRIG_EDGE | ~prev_hit).
- Mask of all zeros: hit=1 every cycle.
  - Level mode then fires on the first armed cycle.
  - Edge mode never fires.
- Latency: word W on SEQ_IN in cycle c gives hit in cycle c+1. If W completes the count, SEQ_EXT_START is high in cycle c+2+TRIG_DELAY, and W is on SEQ_OUT in cycle c+3. With TRIG_DELAY=0, the recorder's first stored word is therefore W.
- FSM, registered; ABORT has priority over ARM, which has priority over everything else:
  - IDLE:
    - ARM → ARMED; match counter mcnt := 0.
  - ARMED:
    - On qual: if mcnt+1 ≥ max(TRIG_COUNT,1), go to DELAY with dcnt := 0 when TRIG_DELAY≠0; otherwise fire next edge and follow the post-fire rule.
    - Otherwise mcnt++; mcnt saturates at all-ones.
  - DELAY:
    - dcnt++ each cycle.
    - When dcnt == TRIG_DELAY-1, fire next edge and follow the post-fire rule.
    - Matches are ignored during DELAY.
  - Post-fire:
    - TRIG_CONT=1 → ARMED with mcnt := 0.
    - Otherwise → IDLE.
  - Any state:
    - ABORT → IDLE in the next cycle; a pending pulse is cancelled.
    - ARM outside IDLE restarts: ARMED, mcnt := 0, pending delay discarded.
- Fire:
  - SEQ_EXT_START=1 for exactly one cycle.
  - FIRE_CNT increments with SEQ_EXT_START (wraps at 2^CNT_BITS).
- In continuous mode, matches in the cycle the pulse is registered are not counted; counting resumes the following cycle.
- Config changes while armed take effect immediately, with no glitch protection. Software changes config only in IDLE.
- RST_N deassertion mid-stream: pipeline refills; no pulse can occur until ARM is seen.

Test Plan:
- Level trigger: MASK=FF, VALUE=A5, COUNT=1, DELAY=0, ARM, then SEQ_IN=00,00,A5 in cycles 10,11,12 → SEQ_EXT_START high only in cycle 14; SEQ_OUT=A5 in cycle 15; FIRE_CNT=1; ARMED=0 afterwards.
- Edge and count: TRIG_EDGE=1, COUNT=3, SEQ_IN holds A5 for 4 cycles, then 00, A5, 00, A5 → the held run counts once; pulse 2 cycles after the third rising match; no pulse during the held run.
- Delay: COUNT=1, DELAY=5, match word in cycle c → pulse in cycle c+7; ABORT at c+4 in a second run → no pulse, ARMED=0 at c+5.
- Continuous mode: TRIG_CONT=1, MASK=0F, VALUE=03, SEQ_IN counting 00..FF → pulse every 16 words (SEQ_IN=x3, +2 cycles); FIRE_CNT=16 after 256 words; ARMED stays 1.
- ARM/ABORT simultaneous in ARMED → IDLE; ARM while in DELAY → restart; async RST_N mid-DELAY → all outputs 0 immediately, no pulse after release.
- IN_BITS=32, MASK=FFFF0000, VALUE=12340000 → fires on 1234BEEF, not on 1235BEEF.
